fb_clear_sequencer: RTL and testbench
=====================================

Name: fb_clear_sequencer

Overview:
Avalon-MM bursting write master that fills the framebuffer with the background colour before each frame is rasterised. It drives the HPS f2h_sdram1 write port: 64-bit data, 29-bit word address, 8-bit burstcount. Fill geometry comes from the register file's win_size and back_colour registers. The block is started by a control_status bit and reports done back into control_status.

Parameters:
BURST_MAX, 16, maximum beats per burst (1..128)
ADDR_W, 29, Avalon word-address width (one word = 64 bits = 2 pixels)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a fill; ignored while busy
fb_base  in  ADDR_W  framebuffer base word address; sampled on accepted start
back_colour  in  32  fill pixel (ARGB8888); sampled on accepted start
win_width  in  16  pixels per line; sampled on accepted start
win_height  in  16  lines; sampled on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the fill completes
avm_address  out  ADDR_W  burst start word address
avm_burstcount  out  8  beats in the current burst
avm_writedata  out  64  {back_colour, back_colour}
avm_byteenable  out  8  per-beat byte enables
avm_write  out  1  write request
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset: all outputs 0; state IDLE; all latched registers cleared. Reset has priority over every other input in the same cycle.
- Reset mid-burst: avm_write is 0 on the cycle after the reset edge. The burst is abandoned and no done pulse is issued. Software re-clears after reset.
- Beat accepted = avm_write & ~avm_waitrequest.
- FSM IDLE:
  - start=1 latches all inputs, sets busy, and moves to SETUP.
  - start=0 keeps the FSM in IDLE.
- FSM SETUP (exactly 1 cycle):
  - pixels = win_width*win_height as a 32-bit unsigned product, registered.
  - words_left = (pixels+1)>>1.
  - odd = pixels[0].
  - next_addr = fb_base.
  - If words_left==0, go to DONE; no bus activity.
  - Otherwise go to BURST.
- FSM BURST:
  - On entry: burst_len = min(BURST_MAX, words_left); beats_left = burst_len.
  - avm_address = next_addr and avm_burstcount = burst_len. Both are held constant for every beat of the burst.
  - avm_write=1 continuously. All outputs are stable while avm_waitrequest=1.
  - On each accepted beat: beats_left and words_left decrement.
  - When the last beat of a burst is accepted and words_left becomes nonzero: next_addr += burst_len and a new burst starts the next cycle. avm_write stays high; there is no idle cycle between bursts.
  - When the last beat of the whole fill is accepted, go to DONE.
- FSM DONE (1 cycle): done=1 and busy=0, then return to IDLE. start on this cycle is ignored.
- Timing:
  - Start accepted in cycle 0 → busy=1 and state SETUP in cycle 1.
  - First avm_write=1 in cycle 2.
  - done is asserted the cycle after the final accepted beat.
- Byte enables:
  - 8'hFF on every beat except the final beat of the fill when odd=1.
  - That final beat uses 8'h0F (low pixel only; the high half of the last word is untouched).
- avm_writedata = {back_colour_l, back_colour_l} on every beat.
- Address arithmetic: next_addr wraps modulo 2^ADDR_W. No range check is performed; software guarantees the window fits.
- When not writing, avm_write=0. avm_address, avm_burstcount and avm_byteenable are then don't-care but driven to 0.
- start while busy (SETUP/BURST/DONE): no effect, and the latched parameters are unchanged.

Test Plan:
- BURST_MAX=16, fb_base=0x100, colour=0xFF112233, 4x2, waitrequest=0 → single burst: address 0x100, burstcount 4, four beats of data 0xFF112233FF112233, byteenable FF; done pulse in cycle 6 relative to start; busy high cycles 1–5.
- 3x3 fill → 9 pixels → 5 words in one burst of 5; beats 1–4 use byteenable FF; beat 5 uses 0F.
- 40x1 fill, BURST_MAX=16 → 20 words:
  - burst 1: address base, burstcount 16;
  - burst 2: address base+16, burstcount 4;
  - avm_write never drops between bursts; exactly 20 accepted beats.
- Random avm_waitrequest (50% duty) on a 33x3 fill → address, burstcount, data and byteenable stable during every stall; 50 accepted beats total; last byteenable 0F; done exactly once.
- win_width=0, start → no avm_write ever; done pulses in cycle 2; busy high in cycle 1 only.
- Both cases in one bench:
  - start pulsed again mid-fill → ignored; beat count and address sequence unchanged.
  - reset asserted on beat 7 of a 16-beat burst → avm_write=0 next cycle; busy=0; done never pulses; a subsequent start performs a complete fresh fill.

Source files
------------

// File: rtl/fb_clear_sequencer.sv
// fb_clear_sequencer: Avalon-MM bursting write master that floods the framebuffer
// with the background colour, two pixels per 64-bit word.
module fb_clear_sequencer #(
  parameter int BURST_MAX = 16,
  parameter int ADDR_W = 29
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [31:0]       back_colour,
  input  logic [15:0]       win_width,
  input  logic [15:0]       win_height,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [7:0]        avm_burstcount,
  output logic [63:0]       avm_writedata,
  output logic [7:0]        avm_byteenable,
  output logic              avm_write,
  input  logic              avm_waitrequest
);
  typedef enum logic [1:0] {IDLE, SETUP, BURST, DONE} state_t;
  localparam logic [31:0] BMAX = 32'(BURST_MAX);
  state_t state, state_n;
  logic [ADDR_W-1:0] base_l, next_addr;
  logic [31:0] colour_l, pixels, words_init, words_left, words_dec;
  logic [15:0] width_l, height_l;
  logic [7:0] burst_len, beats_left;
  logic odd, acc, last_beat, last_word;
  function automatic logic [7:0] clip(input logic [31:0] w);
    return w > BMAX ? BMAX[7:0] : w[7:0];
  endfunction
  assign pixels = 32'(width_l) * 32'(height_l);
  assign words_init = 32'((33'(pixels) + 33'd1) >> 1);
  assign words_dec = words_left - 32'd1;
  assign acc = avm_write & ~avm_waitrequest;
  assign last_beat = beats_left == 8'd1;
  assign last_word = words_left == 32'd1;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SETUP : IDLE;
      SETUP:   state_n = words_init == 32'd0 ? DONE : BURST;
      BURST:   state_n = acc && last_word ? DONE : BURST;
      default: state_n = IDLE;
    endcase
  end
  // Bursts chain back to back: the follow-on burst is loaded on the final beat's acceptance.
  always_ff @(posedge clk)
    if (reset) begin
      base_l <= '0;
      colour_l <= '0;
      width_l <= '0;
      height_l <= '0;
      next_addr <= '0;
      words_left <= '0;
      odd <= 1'b0;
      burst_len <= '0;
      beats_left <= '0;
    end else if (state == IDLE && start) begin
      base_l <= fb_base;
      colour_l <= back_colour;
      width_l <= win_width;
      height_l <= win_height;
    end else if (state == SETUP) begin
      next_addr <= base_l;
      words_left <= words_init;
      odd <= pixels[0];
      burst_len <= clip(words_init);
      beats_left <= clip(words_init);
    end else if (state == BURST && acc) begin
      words_left <= words_dec;
      beats_left <= beats_left - 8'd1;
      if (last_beat && !last_word) begin
        next_addr <= next_addr + ADDR_W'(burst_len);
        burst_len <= clip(words_dec);
        beats_left <= clip(words_dec);
      end
    end
  assign busy = state == SETUP || state == BURST;
  assign done = state == DONE;
  assign avm_write = state == BURST;
  assign avm_address = avm_write ? next_addr : '0;
  assign avm_burstcount = avm_write ? burst_len : 8'h00;
  assign avm_writedata = avm_write ? {colour_l, colour_l} : 64'h0;
  assign avm_byteenable = avm_write ? (odd && last_word ? 8'h0F : 8'hFF) : 8'h00;
endmodule

// File: tb/tb_fb_clear_sequencer.sv
// tb_fb_clear_sequencer: directed fills checked cycle by cycle against a beat-list model.
module tb_fb_clear_sequencer;
  localparam int BM = 16;
  logic clk = 0, reset = 1, start = 0;
  logic [28:0] fb_base = '0;
  logic [31:0] back_colour = '0;
  logic [15:0] win_width = '0, win_height = '0;
  logic avm_waitrequest = 0;
  logic busy, done, avm_write;
  logic [28:0] avm_address;
  logic [7:0] avm_burstcount, avm_byteenable;
  logic [63:0] avm_writedata;
  int total = 0, bad = 0, cyc = 0;
  bit chk_en = 0, rand_wr = 0;
  typedef struct {logic [28:0] addr; logic [7:0] bc; logic [7:0] be;} beat_t;
  beat_t exp_q[$];
  logic [31:0] m_colour = '0;
  int m_state = 0;
  int n_acc = 0, n_done = 0, n_write = 0, done_cyc = -1, busy_first = -1, busy_last = -1, start_cyc = 0;
  logic [28:0] obs_addr[$];
  logic [7:0] obs_bc[$], obs_be[$];
  logic stalled = 0;
  logic [28:0] p_addr;
  logic [7:0] p_bc, p_be;
  logic [63:0] p_data;

  fb_clear_sequencer #(.BURST_MAX(BM), .ADDR_W(29)) dut (
    .clk(clk), .reset(reset), .start(start), .fb_base(fb_base), .back_colour(back_colour),
    .win_width(win_width), .win_height(win_height), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_write(avm_write), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected beat list straight from the fill geometry: word k belongs to burst k/BM.
  task automatic build(input logic [28:0] b, input logic [31:0] c, input logic [15:0] w, input logic [15:0] h);
    longint pix, words;
    beat_t bt;
    pix = longint'(w) * longint'(h);
    words = (pix + 1) / 2;
    exp_q.delete();
    m_colour = c;
    for (longint k = 0; k < words; k++) begin
      longint bs;
      bs = (k / BM) * BM;
      bt.addr = b + 29'(bs);
      bt.bc = 8'((words - bs) < BM ? words - bs : BM);
      bt.be = (k == words - 1 && pix[0]) ? 8'h0F : 8'hFF;
      exp_q.push_back(bt);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("busy", busy, m_state == 1 || m_state == 2);
    check("done", done, m_state == 3);
    check("write", avm_write, m_state == 2);
    if (m_state == 2 && exp_q.size() > 0) begin
      check("addr", avm_address, exp_q[0].addr);
      check("burstcount", avm_burstcount, exp_q[0].bc);
      check("writedata", avm_writedata, {m_colour, m_colour});
      check("byteenable", avm_byteenable, exp_q[0].be);
    end else begin
      check("idle_addr", avm_address, 0);
      check("idle_burstcount", avm_burstcount, 0);
      check("idle_byteenable", avm_byteenable, 0);
    end
    if (stalled) begin
      check("stall_addr", avm_address, p_addr);
      check("stall_bc", avm_burstcount, p_bc);
      check("stall_data", avm_writedata, p_data);
      check("stall_be", avm_byteenable, p_be);
    end
    stalled = avm_write && avm_waitrequest && !reset;
    p_addr = avm_address;
    p_bc = avm_burstcount;
    p_be = avm_byteenable;
    p_data = avm_writedata;
    if (avm_write && !avm_waitrequest) begin
      n_acc++;
      obs_addr.push_back(avm_address);
      obs_bc.push_back(avm_burstcount);
      obs_be.push_back(avm_byteenable);
    end
    if (avm_write) n_write++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (reset) begin
      m_state = 0;
      exp_q.delete();
    end else case (m_state)
      0: if (start) begin
        build(fb_base, back_colour, win_width, win_height);
        m_state = 1;
      end
      1: m_state = exp_q.size() == 0 ? 3 : 2;
      2: if (!avm_waitrequest) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_state = 3;
      end
      default: m_state = 0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
    avm_waitrequest = rand_wr ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic clear_logs();
    n_acc = 0; n_done = 0; n_write = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
    obs_addr.delete(); obs_bc.delete(); obs_be.delete();
  endtask

  task automatic start_fill(input logic [28:0] b, input logic [31:0] c, input logic [15:0] w, input logic [15:0] h);
    fb_base = b; back_colour = c; win_width = w; win_height = h;
    clear_logs();
    start = 1;
    start_cyc = cyc;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int n0, k;
    n0 = n_done;
    k = 0;
    while (n_done == n0 && k < maxc) begin
      tick();
      k++;
    end
    if (n_done == n0) begin
      total++;
      bad++;
      $display("FAIL %s: no done within %0d cycles", nm, maxc);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) tick();
    chk_en = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", avm_write, 0);
    check("rst_addr", avm_address, 0);
    check("rst_data", avm_writedata, 0);
    check("rst_be", avm_byteenable, 0);
    tick();
    reset = 0;
    repeat (2) tick();

    start_fill(29'h100, 32'hFF112233, 16'd4, 16'd2);
    wait_done(50, "t1_done");
    check("t1_done_cyc", done_cyc - start_cyc, 6);
    check("t1_busy_first", busy_first - start_cyc, 1);
    check("t1_busy_last", busy_last - start_cyc, 5);
    check("t1_beats", n_acc, 4);
    check("t1_addr0", obs_addr[0], 29'h100);
    check("t1_bc0", obs_bc[0], 4);

    start_fill(29'h40, 32'h00ABCDEF, 16'd3, 16'd3);
    repeat (5) tick();
    start = 1;
    fb_base = 29'h999;
    tick();
    start = 0;
    repeat (3) tick();
    check("t2_dones", n_done, 1);
    check("t2_done_cyc", done_cyc - start_cyc, 7);
    check("t2_beats", n_acc, 5);
    check("t2_be3", obs_be[3], 8'hFF);
    check("t2_be4", obs_be[4], 8'h0F);
    check("t2_idle_after", busy, 0);

    start_fill(29'h1FFFFFF8, 32'h12345678, 16'd40, 16'd1);
    wait_done(100, "t3_done");
    check("t3_beats", n_acc, 20);
    check("t3_write_cycles", n_write, 20);
    check("t3_done_cyc", done_cyc - start_cyc, 22);
    check("t3_addr0", obs_addr[0], 29'h1FFFFFF8);
    check("t3_bc0", obs_bc[0], 16);
    check("t3_addr15", obs_addr[15], 29'h1FFFFFF8);
    check("t3_addr16_wrap", obs_addr[16], 29'h8);
    check("t3_bc16", obs_bc[16], 4);
    check("t3_be19", obs_be[19], 8'hFF);

    start_fill(29'h50, 32'hAAAA5555, 16'd0, 16'd7);
    wait_done(20, "t4_done");
    check("t4_done_cyc", done_cyc - start_cyc, 2);
    check("t4_busy_first", busy_first - start_cyc, 1);
    check("t4_busy_last", busy_last - start_cyc, 1);
    check("t4_writes", n_write, 0);

    rand_wr = 1;
    start_fill(29'h300, 32'hCAFEF00D, 16'd33, 16'd3);
    k = 0;
    while (n_acc < 20 && k < 1000) begin
      tick();
      k++;
    end
    fb_base = 29'h7777; back_colour = 32'h0; win_width = 16'd1; start = 1;
    tick();
    start = 0;
    wait_done(2000, "t5_done");
    rand_wr = 0;
    tick();
    check("t5_beats", n_acc, 50);
    check("t5_dones", n_done, 1);
    check("t5_addr47", obs_addr[47], 29'h320);
    check("t5_addr48", obs_addr[48], 29'h330);
    check("t5_bc48", obs_bc[48], 2);
    check("t5_be48", obs_be[48], 8'hFF);
    check("t5_be49", obs_be[49], 8'h0F);

    start_fill(29'h1000, 32'h0F0F0F0F, 16'd32, 16'd1);
    k = 0;
    while (n_acc < 6 && k < 100) begin
      tick();
      k++;
    end
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    check("t6_write_after_rst", avm_write, 0);
    check("t6_busy_after_rst", busy, 0);
    repeat (5) tick();
    check("t6_no_done", n_done, 0);
    check("t6_beats_before_rst", n_acc, 7);
    start_fill(29'h1000, 32'h0F0F0F0F, 16'd32, 16'd1);
    wait_done(60, "t6_refill_done");
    check("t6_refill_beats", n_acc, 16);
    check("t6_refill_dones", n_done, 1);
    check("t6_refill_done_cyc", done_cyc - start_cyc, 18);
    check("t6_refill_addr15", obs_addr[15], 29'h1000);
    check("t6_refill_be15", obs_be[15], 8'hFF);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
